mips_decode_exec: RTL and testbench
===================================

Name: mips_decode_exec

Overview:
- Combined MIPS main decoder, ALU-control decoder and 32-bit ALU, followed by one output register stage.
- Takes a decoded-stage instruction plus forwarded register operands.
- Produces the registered EX/MEM bundle: ALU result, zero flag, pass-through control bits, write register, store data and branch decision.
- Sits between the register-file read/forwarding logic and the data-memory stage of the five-stage pipeline.

Parameters:
DATA_W, 32, operand/result width; the immediate is sign-extended to DATA_W; must be >= 16.

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
flush  input  1  synchronous bubble insert: registered outputs take reset values on next edge
instr  input  32  instruction word (opcode [31:26], rt [20:16], rd [15:11], shamt [10:6], funct [5:0], imm [15:0])
rs_data  input  DATA_W  forwarded rs operand (ALU input A)
rt_data  input  DATA_W  forwarded rt operand (ALU input B when alusrc=0, store data)
alu_result  output  DATA_W  registered ALU output
zero  output  1  registered (ALU output == 0)
regwrite  output  1  registered control
memread  output  1  registered control
memwrite  output  1  registered control
memtoreg  output  1  registered control
jump  output  1  registered control
pcsrc  output  1  registered branch-taken
wrreg  output  5  registered destination: rd if regdst else rt
store_data  output  DATA_W  registered rt_data

Behaviour:
- Reset: on a clk edge with rst_n=0, all outputs go to 0. Reset has priority over flush.
- Latency: combinational decode/ALU from current inputs, captured at the next edge; exactly 1-cycle latency. No handshake; a new instruction is accepted every cycle.
- Main decode, listed as opcode -> signals set (all other signals 0):
  - 000000 R-type -> regdst, regwrite, aluop=10
  - 100011 lw -> memread, memtoreg, alusrc, regwrite, aluop=00
  - 101011 sw -> memwrite, alusrc, aluop=00
  - 000100 beq -> branch_eq, aluop=01
  - 000101 bne -> branch_ne, aluop=01
  - 001000 addi -> alusrc, regwrite, aluop=00
  - 000010 j -> jump
  - any other opcode -> all signals 0 (acts as a nop).
- ALU-control, aluop -> aluctl:
  - 00 -> 0010 (add); 01 -> 0110 (sub); 11 -> 1111.
  - 10 uses funct: 100000 -> 0010 add; 100010 -> 0110 sub; 100100 -> 0000 and; 100101 -> 0001 or; 100110 -> 0011 xor; 100111 -> 1100 nor; 101010 -> 0111 slt; any other funct -> 1111.
- ALU operands: B = sign-extended imm[15:0] when alusrc=1, else rt_data.
- ALU results by aluctl:
  - add/sub: modulo 2^DATA_W, no overflow detection.
  - slt: signed compare, result 1 or 0.
  - 1111 or any unlisted code: result 0.
- zero = (result == 0), evaluated on the unregistered result.
- pcsrc = (branch_eq & zero_comb) | (branch_ne & ~zero_comb), registered.
- flush=1 (rst_n=1): regwrite, memread, memwrite, memtoreg, jump, pcsrc, wrreg, alu_result, store_data and zero all load 0 at the next edge.
- Store data is rt_data unmodified, including on flush-free cycles for non-store instructions.
- Unknown opcode with funct bits set: no side effects (regwrite=memwrite=0).

Optional Feature:
MIPS_ALU_SHIFT_EN
- Defined: with aluop=10, funct 000000 (sll) -> aluctl 1000, result = B << shamt; funct 000010 (srl) -> aluctl 1001, result = B >> shamt (logical). instr=0 is therefore sll $0,$0,0 with regwrite=1 and wrreg=0.
- Undefined: both functs map to 1111 and give result 0; regwrite still 1 per R-type decode.

Test Plan:
- Reset: rst_n=0 for 2 edges with instr=add -> all outputs 0; release -> outputs follow the next edge.
- R-type add $3,$1,$2 with rs=5, rt=7 -> next edge alu_result=12, wrreg=3, regwrite=1, zero=0; sub with rs=rt=9 -> alu_result=0, zero=1.
- slt signed: rs=0xFFFFFFFF, rt=1 -> alu_result=1; swapped operands -> 0. and/or/nor/xor with 0xF0F0/0x0FF0 -> 0x00F0/0xFFF0/0xFFFF000F/0xFF00.
- lw rt=4, imm=0xFFFC, rs=0x100 -> alu_result=0xFC, memread=1, memtoreg=1, wrreg=4. sw: rt_data=0xABCD -> store_data=0xABCD, memwrite=1, regwrite=0.
- beq rs=rt=3 -> pcsrc=1; bne same operands -> pcsrc=0; bne rs=3, rt=4 -> pcsrc=1; j -> jump=1, pcsrc=0.
- flush asserted on the beq-taken cycle -> pcsrc=0 and all controls 0 at that edge; flush and rst_n=0 together -> same reset values. Unknown opcode 111111 -> all controls 0.

Source files
------------

// File: rtl/mips_decode_exec.sv
// MIPS main decoder, ALU-control decoder and DATA_W-bit ALU feeding one EX/MEM register stage.
// Optional MIPS_ALU_SHIFT_EN adds sll/srl (funct 000000/000010) to the R-type ALU operations.
module mips_decode_exec #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic [31:0]       instr,
   input  logic [DATA_W-1:0] rs_data,
   input  logic [DATA_W-1:0] rt_data,
   output logic [DATA_W-1:0] alu_result,
   output logic              zero,
   output logic              regwrite,
   output logic              memread,
   output logic              memwrite,
   output logic              memtoreg,
   output logic              jump,
   output logic              pcsrc,
   output logic [4:0]        wrreg,
   output logic [DATA_W-1:0] store_data
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_XOR  = 4'b0011;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SLT  = 4'b0111;
   localparam logic [3:0] ALU_SLL  = 4'b1000;
   localparam logic [3:0] ALU_SRL  = 4'b1001;
   localparam logic [3:0] ALU_NOR  = 4'b1100;
   localparam logic [3:0] ALU_NONE = 4'b1111;

   logic [5:0]        w_opcode;
   logic [4:0]        w_rt;
   logic [4:0]        w_rd;
   logic [4:0]        w_shamt;
   logic [5:0]        w_funct;
   logic [DATA_W-1:0] w_imm_ext;

   logic              w_regdst;
   logic              w_regwrite;
   logic              w_memread;
   logic              w_memwrite;
   logic              w_memtoreg;
   logic              w_alusrc;
   logic              w_branch_eq;
   logic              w_branch_ne;
   logic              w_jump;
   logic [1:0]        w_aluop;
   logic [3:0]        w_aluctl;

   logic [DATA_W-1:0] w_alu_b;
   logic [DATA_W-1:0] w_result;
   logic              w_zero;
   logic              w_pcsrc;
   logic [4:0]        w_wrreg;

   logic [DATA_W-1:0] r_alu_result;
   logic              r_zero;
   logic              r_regwrite;
   logic              r_memread;
   logic              r_memwrite;
   logic              r_memtoreg;
   logic              r_jump;
   logic              r_pcsrc;
   logic [4:0]        r_wrreg;
   logic [DATA_W-1:0] r_store_data;

   // rs arrives already read and forwarded, so its field is not needed here
   logic              w_unused_bits;

   assign w_opcode  = instr[31:26];
   assign w_rt      = instr[20:16];
   assign w_rd      = instr[15:11];
   assign w_shamt   = instr[10:6];
   assign w_funct   = instr[5:0];
   assign w_imm_ext = DATA_W'($signed(instr[15:0]));

`ifdef MIPS_ALU_SHIFT_EN
   assign w_unused_bits = ^instr[25:21];
`else
   assign w_unused_bits = ^{instr[25:21], w_shamt};
`endif

   always_comb begin
      w_regdst    = 1'b0;
      w_regwrite  = 1'b0;
      w_memread   = 1'b0;
      w_memwrite  = 1'b0;
      w_memtoreg  = 1'b0;
      w_alusrc    = 1'b0;
      w_branch_eq = 1'b0;
      w_branch_ne = 1'b0;
      w_jump      = 1'b0;
      w_aluop     = 2'b00;
      case (w_opcode)
         OP_RTYPE: begin
            w_regdst   = 1'b1;
            w_regwrite = 1'b1;
            w_aluop    = 2'b10;
         end
         OP_LW: begin
            w_memread  = 1'b1;
            w_memtoreg = 1'b1;
            w_alusrc   = 1'b1;
            w_regwrite = 1'b1;
         end
         OP_SW: begin
            w_memwrite = 1'b1;
            w_alusrc   = 1'b1;
         end
         OP_BEQ: begin
            w_branch_eq = 1'b1;
            w_aluop     = 2'b01;
         end
         OP_BNE: begin
            w_branch_ne = 1'b1;
            w_aluop     = 2'b01;
         end
         OP_ADDI: begin
            w_alusrc   = 1'b1;
            w_regwrite = 1'b1;
         end
         OP_J:    w_jump = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      w_aluctl = ALU_NONE;
      case (w_aluop)
         2'b00: w_aluctl = ALU_ADD;
         2'b01: w_aluctl = ALU_SUB;
         2'b10: begin
            case (w_funct)
               6'b100000: w_aluctl = ALU_ADD;
               6'b100010: w_aluctl = ALU_SUB;
               6'b100100: w_aluctl = ALU_AND;
               6'b100101: w_aluctl = ALU_OR;
               6'b100110: w_aluctl = ALU_XOR;
               6'b100111: w_aluctl = ALU_NOR;
               6'b101010: w_aluctl = ALU_SLT;
`ifdef MIPS_ALU_SHIFT_EN
               6'b000000: w_aluctl = ALU_SLL;
               6'b000010: w_aluctl = ALU_SRL;
`endif
               default:   w_aluctl = ALU_NONE;
            endcase
         end
         default: w_aluctl = ALU_NONE;
      endcase
   end

   assign w_alu_b = w_alusrc ? w_imm_ext : rt_data;

   always_comb begin
      w_result = '0;
      case (w_aluctl)
         ALU_AND: w_result = rs_data & w_alu_b;
         ALU_OR:  w_result = rs_data | w_alu_b;
         ALU_ADD: w_result = rs_data + w_alu_b;
         ALU_XOR: w_result = rs_data ^ w_alu_b;
         ALU_SUB: w_result = rs_data - w_alu_b;
         ALU_SLT: w_result = DATA_W'($signed(rs_data) < $signed(w_alu_b));
         ALU_NOR: w_result = ~(rs_data | w_alu_b);
`ifdef MIPS_ALU_SHIFT_EN
         ALU_SLL: w_result = w_alu_b << w_shamt;
         ALU_SRL: w_result = w_alu_b >> w_shamt;
`endif
         default: w_result = '0;
      endcase
   end

   assign w_zero  = (w_result == '0);
   assign w_pcsrc = (w_branch_eq & w_zero) | (w_branch_ne & ~w_zero);
   assign w_wrreg = w_regdst ? w_rd : w_rt;

   // Reset wins over flush; both collapse the stage to a bubble
   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         r_alu_result <= '0;
         r_zero       <= 1'b0;
         r_regwrite   <= 1'b0;
         r_memread    <= 1'b0;
         r_memwrite   <= 1'b0;
         r_memtoreg   <= 1'b0;
         r_jump       <= 1'b0;
         r_pcsrc      <= 1'b0;
         r_wrreg      <= '0;
         r_store_data <= '0;
      end else begin
         r_alu_result <= w_result;
         r_zero       <= w_zero;
         r_regwrite   <= w_regwrite;
         r_memread    <= w_memread;
         r_memwrite   <= w_memwrite;
         r_memtoreg   <= w_memtoreg;
         r_jump       <= w_jump;
         r_pcsrc      <= w_pcsrc;
         r_wrreg      <= w_wrreg;
         r_store_data <= rt_data;
      end
   end

   assign alu_result = r_alu_result;
   assign zero       = r_zero;
   assign regwrite   = r_regwrite;
   assign memread    = r_memread;
   assign memwrite   = r_memwrite;
   assign memtoreg   = r_memtoreg;
   assign jump       = r_jump;
   assign pcsrc      = r_pcsrc;
   assign wrreg      = r_wrreg;
   assign store_data = r_store_data;

endmodule

// File: tb/tb_mips_decode_exec.sv
// Scoreboard bench for mips_decode_exec: directed cases then random instructions against a
// behavioural model; expected EX/MEM bundles are queued at issue and checked one edge later.
module tb_mips_decode_exec;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic [31:0] instr;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic [31:0] alu_result;
   logic        zero;
   logic        regwrite;
   logic        memread;
   logic        memwrite;
   logic        memtoreg;
   logic        jump;
   logic        pcsrc;
   logic [4:0]  wrreg;
   logic [31:0] store_data;

   typedef struct packed {
      logic [31:0] res;
      logic        zero;
      logic        regwrite;
      logic        memread;
      logic        memwrite;
      logic        memtoreg;
      logic        jump;
      logic        pcsrc;
      logic [4:0]  wrreg;
      logic [31:0] store;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   mips_decode_exec #(.DATA_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .instr(instr),
      .rs_data(rs_data), .rt_data(rt_data), .alu_result(alu_result), .zero(zero),
      .regwrite(regwrite), .memread(memread), .memwrite(memwrite), .memtoreg(memtoreg),
      .jump(jump), .pcsrc(pcsrc), .wrreg(wrreg), .store_data(store_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] r_op(input logic [4:0] rd, input logic [4:0] rt,
                                        input logic [4:0] sh, input logic [5:0] fn);
      return {6'b000000, 5'd1, rt, rd, sh, fn};
   endfunction

   function automatic logic [31:0] i_op(input logic [5:0] op, input logic [4:0] rt,
                                        input logic [15:0] imm);
      return {op, 5'd1, rt, imm};
   endfunction

   // Architectural meaning of each instruction, straight from the ISA description
   function automatic exp_t model(input logic rst_ok, input logic fl, input logic [31:0] ins,
                                  input logic [31:0] a, input logic [31:0] b);
      exp_t        e;
      logic [31:0] imm;
      logic [5:0]  op;
      logic [5:0]  fn;
      e   = '0;
      op  = ins[31:26];
      fn  = ins[5:0];
      imm = {{16{ins[15]}}, ins[15:0]};
      if (!rst_ok || fl) return e;
      e.store = b;
      e.wrreg = ins[20:16];
      case (op)
         6'b000000: begin
            e.regwrite = 1'b1;
            e.wrreg    = ins[15:11];
            case (fn)
               6'b100000: e.res = a + b;
               6'b100010: e.res = a - b;
               6'b100100: e.res = a & b;
               6'b100101: e.res = a | b;
               6'b100110: e.res = a ^ b;
               6'b100111: e.res = ~(a | b);
               6'b101010: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
`ifdef MIPS_ALU_SHIFT_EN
               6'b000000: e.res = b << ins[10:6];
               6'b000010: e.res = b >> ins[10:6];
`endif
               default:   e.res = 32'd0;
            endcase
         end
         6'b100011: begin e.res = a + imm; e.memread = 1'b1; e.memtoreg = 1'b1; e.regwrite = 1'b1; end
         6'b101011: begin e.res = a + imm; e.memwrite = 1'b1; end
         6'b001000: begin e.res = a + imm; e.regwrite = 1'b1; end
         6'b000100: begin e.res = a - b; e.pcsrc = (a == b); end
         6'b000101: begin e.res = a - b; e.pcsrc = (a != b); end
         6'b000010: begin e.res = a + b; e.jump = 1'b1; end
         default:   e.res = a + b;
      endcase
      e.zero = (e.res == 32'd0);
      return e;
   endfunction

   task automatic issue(input logic rn, input logic fl, input logic [31:0] ins,
                        input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      rst_n   = rn;
      flush   = fl;
      instr   = ins;
      rs_data = a;
      rt_data = b;
      exp_q.push_back(model(rn, fl, ins, a, b));
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("alu_result", alu_result, e.res);
            chk("zero",       32'(zero),     32'(e.zero));
            chk("regwrite",   32'(regwrite), 32'(e.regwrite));
            chk("memread",    32'(memread),  32'(e.memread));
            chk("memwrite",   32'(memwrite), 32'(e.memwrite));
            chk("memtoreg",   32'(memtoreg), 32'(e.memtoreg));
            chk("jump",       32'(jump),     32'(e.jump));
            chk("pcsrc",      32'(pcsrc),    32'(e.pcsrc));
            chk("wrreg",      32'(wrreg),    32'(e.wrreg));
            chk("store_data", store_data,    e.store);
         end
      end
   end

   initial begin : stimulus
      logic [5:0]  ops [10];
      logic [5:0]  fns [11];
      logic [5:0]  op;
      logic [5:0]  fn;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] ins;
      int          budget;

      ops = '{6'b000000, 6'b000000, 6'b100011, 6'b101011, 6'b000100,
              6'b000101, 6'b001000, 6'b000010, 6'b111111, 6'b011010};
      fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b100111,
              6'b101010, 6'b000000, 6'b000010, 6'b111001, 6'b100001};

      rst_n = 1'b0; flush = 1'b0; instr = '0; rs_data = '0; rt_data = '0;

      issue(1'b0, 1'b0, r_op(5'd3, 5'd2, 5'd0, 6'b100000), 32'd5, 32'd7);
      issue(1'b0, 1'b0, r_op(5'd3, 5'd2, 5'd0, 6'b100000), 32'd5, 32'd7);
      issue(1'b1, 1'b0, r_op(5'd3, 5'd2, 5'd0, 6'b100000), 32'd5, 32'd7);
      issue(1'b1, 1'b0, r_op(5'd3, 5'd2, 5'd0, 6'b100010), 32'd9, 32'd9);
      issue(1'b1, 1'b0, r_op(5'd4, 5'd2, 5'd0, 6'b101010), 32'hFFFF_FFFF, 32'd1);
      issue(1'b1, 1'b0, r_op(5'd4, 5'd2, 5'd0, 6'b101010), 32'd1, 32'hFFFF_FFFF);
      issue(1'b1, 1'b0, r_op(5'd5, 5'd2, 5'd0, 6'b100100), 32'hF0F0, 32'h0FF0);
      issue(1'b1, 1'b0, r_op(5'd5, 5'd2, 5'd0, 6'b100101), 32'hF0F0, 32'h0FF0);
      issue(1'b1, 1'b0, r_op(5'd5, 5'd2, 5'd0, 6'b100111), 32'hF0F0, 32'h0FF0);
      issue(1'b1, 1'b0, r_op(5'd5, 5'd2, 5'd0, 6'b100110), 32'hF0F0, 32'h0FF0);
      issue(1'b1, 1'b0, i_op(6'b100011, 5'd4, 16'hFFFC), 32'h100, 32'h55);
      issue(1'b1, 1'b0, i_op(6'b101011, 5'd6, 16'h0010), 32'h200, 32'hABCD);
      issue(1'b1, 1'b0, i_op(6'b000100, 5'd2, 16'h0004), 32'd3, 32'd3);
      issue(1'b1, 1'b0, i_op(6'b000101, 5'd2, 16'h0004), 32'd3, 32'd3);
      issue(1'b1, 1'b0, i_op(6'b000101, 5'd2, 16'h0004), 32'd3, 32'd4);
      issue(1'b1, 1'b0, {6'b000010, 26'h0000123}, 32'd3, 32'd4);
      issue(1'b1, 1'b1, i_op(6'b000100, 5'd2, 16'h0004), 32'd3, 32'd3);
      issue(1'b0, 1'b1, r_op(5'd3, 5'd2, 5'd0, 6'b100000), 32'd5, 32'd7);
      issue(1'b1, 1'b0, {6'b111111, 26'h3FF_FFFF}, 32'd8, 32'd9);
      issue(1'b1, 1'b0, 32'h0000_0000, 32'h1234, 32'h8000_0001);
      issue(1'b1, 1'b0, r_op(5'd7, 5'd2, 5'd4, 6'b000010), 32'h1, 32'h8000_00F0);
      issue(1'b1, 1'b0, r_op(5'd7, 5'd2, 5'd0, 6'b111001), 32'h1, 32'h2);

      for (int i = 0; i < 400; i++) begin
         op = ops[$urandom_range(9, 0)];
         fn = fns[$urandom_range(10, 0)];
         a  = $urandom();
         b  = ($urandom_range(3, 0) == 0) ? a : $urandom();
         ins = {op, 5'($urandom()), 5'($urandom()), 5'($urandom()), 5'($urandom()), fn};
         if (op != 6'b000000) ins[15:0] = 16'($urandom());
         issue(($urandom_range(19, 0) != 0), ($urandom_range(9, 0) == 0), ins, a, b);
      end

      issue(1'b1, 1'b0, 32'h0000_0000, 32'd0, 32'd0);
      budget = 20;
      while (exp_q.size() > 0 && budget > 0) begin
         @(posedge clk);
         budget--;
      end
      @(negedge clk);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
